// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU: round-robin grant, single-cycle
// ops complete in EXEC, mod ops wait for alu_done or time out, response held until taken.
module alu_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_sel,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_sel,
  input  logic        req1_cin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_timeout,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_cin,
  output logic        alu_start,
  output logic        alu_reset,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  input  logic        alu_done,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and response fields hold while rsp_valid is
  // high and rsp_ready is low.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [2:0] SEL_MOD = 3'b111;
  localparam int         CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  logic          r_last_grant;
  logic [31:0]   r_op_a;
  logic [31:0]   r_op_b;
  logic [2:0]    r_op_sel;
  logic          r_op_cin;
  logic          r_op_id;
  logic          r_drive;
  logic          r_alu_start;
  logic          r_to_pulse;
  logic [CW-1:0] r_cnt;
  logic          r_rsp_valid;
  logic          r_rsp_id;
  logic [31:0]   r_rsp_result;
  logic          r_rsp_cout;
  logic          r_rsp_timeout;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any;

  // On a tie the requester that was not served last wins.
  assign w_idle = (r_state == S_IDLE) && !reset;
  assign w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
  assign w_gnt0 = req0_valid && !w_gnt1;
  assign w_any  = req0_valid || req1_valid;

  assign req0_ready = w_idle && w_gnt0;
  assign req1_ready = w_idle && w_gnt1;

  assign alu_a     = r_drive ? r_op_a   : 32'd0;
  assign alu_b     = r_drive ? r_op_b   : 32'd0;
  assign alu_sel   = r_drive ? r_op_sel : 3'd0;
  assign alu_cin   = r_drive ? r_op_cin : 1'b0;
  assign alu_start = r_alu_start;
  assign alu_reset = reset || r_to_pulse;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_cout    = r_rsp_cout;
  assign rsp_timeout = r_rsp_timeout;
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_op_a        <= 32'd0;
      r_op_b        <= 32'd0;
      r_op_sel      <= 3'd0;
      r_op_cin      <= 1'b0;
      r_op_id       <= 1'b0;
      r_drive       <= 1'b0;
      r_alu_start   <= 1'b0;
      r_to_pulse    <= 1'b0;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_result  <= 32'd0;
      r_rsp_cout    <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      r_to_pulse  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op_a      <= w_gnt1 ? req1_a   : req0_a;
            r_op_b      <= w_gnt1 ? req1_b   : req0_b;
            r_op_sel    <= w_gnt1 ? req1_sel : req0_sel;
            r_op_cin    <= w_gnt1 ? req1_cin : req0_cin;
            r_op_id     <= w_gnt1;
            r_drive     <= 1'b1;
            r_alu_start <= ((w_gnt1 ? req1_sel : req0_sel) == SEL_MOD);
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_op_sel != SEL_MOD) begin
            r_rsp_result  <= alu_result;
            r_rsp_cout    <= alu_cout;
            r_rsp_timeout <= 1'b0;
            r_rsp_id      <= r_op_id;
            r_rsp_valid   <= 1'b1;
            r_drive       <= 1'b0;
            r_state       <= S_RESP;
          end else begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // alu_done takes priority over an expiring counter in the same cycle.
          if (alu_done) begin
            r_rsp_result  <= alu_result;
            r_rsp_cout    <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_id      <= r_op_id;
            r_rsp_valid   <= 1'b1;
            r_drive       <= 1'b0;
            r_state       <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_result  <= 32'd0;
            r_rsp_cout    <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_rsp_id      <= r_op_id;
            r_rsp_valid   <= 1'b1;
            r_drive       <= 1'b0;
            r_to_pulse    <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_last_grant <= r_rsp_id;
            r_rsp_valid  <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU (AND/OR/XOR/ADD and
// a mod unit that answers after 10 WAIT cycles when enabled).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_sel, req1_sel;
  logic        req0_cin, req1_cin;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_timeout;
  logic [31:0] rsp_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_sel;
  logic        alu_cin, alu_start, alu_reset, alu_cout, alu_done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_WAIT = 2'd2, ST_RESP = 2'd3;

  alu_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_timeout(rsp_timeout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_start(alu_start), .alu_reset(alu_reset),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_done(alu_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  logic       mod_en = 1'b0;
  logic [3:0] mod_cnt = 4'd0;
  int         start_pulses = 0;

  always_comb begin
    alu_cout   = 1'b0;
    alu_result = 32'd0;
    case (alu_sel)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a ^ alu_b;
      3'b011: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
      3'b111: alu_result = (alu_b != 32'd0) ? (alu_a % alu_b) : 32'd0;
      default: alu_result = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (alu_start) mod_cnt <= 4'd1;
    else if (mod_cnt == 4'd10) mod_cnt <= 4'd0;
    else if (mod_cnt != 4'd0) mod_cnt <= mod_cnt + 4'd1;
    if (alu_start) start_pulses <= start_pulses + 1;
  end

  assign alu_done = mod_en && (mod_cnt == 4'd10);

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] sel, input logic cin);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; req0_cin = cin;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; req1_cin = cin;
    end
  endtask

  task automatic idle_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Steps from EXEC until rsp_valid; k counts negedges, n_rst counts alu_reset samples.
  task automatic wait_rsp(output int k, output int n_rst);
    k = 0;
    n_rst = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (alu_reset) n_rst++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check("rsp_wait_bound", 32'(k), 32'd100 + 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k, n_rst, exp_id;
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_sel = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_sel = '0; req1_cin = 1'b0;

    // Reset state, including ready gating while reset is held
    @(negedge clk);
    req0_valid = 1'b1;
    @(negedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_reset", 32'(alu_reset), 32'd1);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);

    // AND from req0, T+2 latency
    @(negedge clk);
    reset = 1'b0; rsp_ready = 1'b1;
    drive_req(0, 32'd7, 32'd5, 3'b000, 1'b0);
    #1;
    check("and_req0_ready", 32'(req0_ready), 32'd1);
    check("and_req1_ready", 32'(req1_ready), 32'd0);
    check("and_alu_reset_rel", 32'(alu_reset), 32'd0);
    @(negedge clk);
    idle_reqs();
    #1;
    check("and_exec_state", 32'(dbg_state), 32'(ST_EXEC));
    check("and_exec_alu_a", alu_a, 32'd7);
    check("and_exec_ready", 32'(req0_ready), 32'd0);
    check("and_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("and_rsp_valid", 32'(rsp_valid), 32'd1);
    check("and_rsp_id", 32'(rsp_id), 32'd0);
    check("and_rsp_result", rsp_result, 32'd5);
    check("and_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge clk);
    check("and_back_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("and_idle_alu_a", alu_a, 32'd0);

    // Both valid: last served was 0, so grants run 1,0,1,0
    drive_req(0, 32'h0000_00F0, 32'h0000_000F, 3'b001, 1'b0);
    drive_req(1, 32'h0000_00FF, 32'h0000_000F, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 0) ? 1 : 0;
      #1;
      check("rr_ready0", 32'(req0_ready), 32'(exp_id == 0));
      check("rr_ready1", 32'(req1_ready), 32'(exp_id == 1));
      @(negedge clk);
      @(negedge clk);
      check("rr_rsp_id", 32'(rsp_id), 32'(exp_id));
      check("rr_rsp_result", rsp_result, (exp_id == 0) ? 32'h0000_00FF : 32'h0000_00F0);
      @(negedge clk);
    end
    idle_reqs();
    @(negedge clk);

    // Mod from req1, ALU answers after 10 WAIT cycles
    mod_en = 1'b1;
    start_pulses = 0;
    drive_req(1, 32'd17, 32'd5, 3'b111, 1'b0);
    #1;
    check("mod_ready1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    idle_reqs();
    #1;
    check("mod_exec_start", 32'(alu_start), 32'd1);
    wait_rsp(k, n_rst);
    check("mod_latency", 32'(k), 32'd11);
    check("mod_start_pulses", 32'(start_pulses), 32'd1);
    check("mod_rsp_result", rsp_result, 32'd2);
    check("mod_rsp_id", 32'(rsp_id), 32'd1);
    check("mod_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("mod_rsp_cout", 32'(rsp_cout), 32'd0);
    @(negedge clk);

    // Mod timeout from req0: 64 WAIT cycles then one alu_reset pulse
    mod_en = 1'b0;
    drive_req(0, 32'd9, 32'd4, 3'b111, 1'b0);
    @(negedge clk);
    idle_reqs();
    wait_rsp(k, n_rst);
    check("to_latency", 32'(k), 32'd65);
    check("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    check("to_rsp_result", rsp_result, 32'd0);
    check("to_rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    if (alu_reset) n_rst++;
    check("to_alu_reset_pulses", 32'(n_rst), 32'd1);
    check("to_back_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Backpressure: ADD with carry, response held 5 cycles, req1 wins the tie
    rsp_ready = 1'b0;
    drive_req(0, 32'd3, 32'd1, 3'b000, 1'b0);
    drive_req(1, 32'hFFFF_FFFF, 32'd0, 3'b011, 1'b1);
    #1;
    check("bp_ready1", 32'(req1_ready), 32'd1);
    check("bp_ready0", 32'(req0_ready), 32'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req1_a = 32'(i + 100);
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_result", rsp_result, 32'd0);
      check("bp_rsp_cout", 32'(rsp_cout), 32'd1);
      check("bp_rsp_id", 32'(rsp_id), 32'd1);
      check("bp_ready0_low", 32'(req0_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("bp_release_ready0", 32'(req0_ready), 32'd1);
    @(negedge clk);
    idle_reqs();
    @(negedge clk);
    check("bp_next_rsp_id", 32'(rsp_id), 32'd0);
    check("bp_next_rsp_result", rsp_result, 32'd1);
    @(negedge clk);

    // Reset during WAIT aborts; next tie goes to req0
    drive_req(1, 32'd100, 32'd7, 3'b111, 1'b0);
    @(negedge clk);
    idle_reqs();
    repeat (3) @(negedge clk);
    check("rw_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    reset = 1'b1;
    @(negedge clk);
    check("rw_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_alu_start", 32'(alu_start), 32'd0);
    check("rw_alu_reset", 32'(alu_reset), 32'd1);
    reset = 1'b0;
    drive_req(0, 32'd3, 32'd1, 3'b010, 1'b0);
    drive_req(1, 32'd8, 32'd8, 3'b000, 1'b0);
    #1;
    check("rw_tie_ready0", 32'(req0_ready), 32'd1);
    check("rw_tie_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    idle_reqs();
    @(negedge clk);
    check("rw_rsp_id", 32'(rsp_id), 32'd0);
    check("rw_rsp_result", rsp_result, 32'd2);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
